// File: rtl/quant_scheduler.sv
// Round-robin issue scheduler that time-shares one pipelined quantizer between
// the Y/Cb/Cr producers and routes each completion back as a per-channel done.
module quant_scheduler #(
  parameter int LATENCY   = 4,
  parameter int ISSUE_GAP = 2,
  parameter int MAX_OUT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic       q_enable,
  output logic [1:0] q_sel,
  input  logic       q_out_enable,
  output logic [2:0] done,
  output logic       busy,
  output logic       err_underflow
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(ISSUE_GAP);
  localparam logic [CW-1:0] FULL       = CW'(MAX_OUT);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(ISSUE_GAP - 1);

  if (LATENCY < 1 || ISSUE_GAP < 2 || MAX_OUT < 2 || (MAX_OUT & (MAX_OUT - 1)) != 0) begin : g_bad_param
    $error("quant_scheduler: illegal parameter combination");
  end

  typedef enum logic [1:0] {CH_Y = 2'd0, CH_CB = 2'd1, CH_CR = 2'd2} ch_e;

  function automatic ch_e next_ch(input ch_e c);
    case (c)
      CH_Y:    return CH_CB;
      CH_CB:   return CH_CR;
      default: return CH_Y;
    endcase
  endfunction

  function automatic logic [2:0] onehot(input ch_e c);
    return 3'b001 << c;
  endfunction

  ch_e           rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    gnt_q, gnt_d;
  logic          q_enable_q, q_enable_d;
  ch_e           q_sel_q, q_sel_d;
  logic [2:0]    done_q, done_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  ch_e           tag_mem_q [MAX_OUT];

  ch_e  c0, c1, c2, win;
  logic win_found, issue, pop, underflow;

  // NOTE: every always_comb output gets a default assignment before any branch,
  // so no path can leave a value unassigned and infer a latch.
  always_comb begin
    c0        = rr_ptr_q;
    c1        = next_ch(c0);
    c2        = next_ch(c1);
    win       = c0;
    win_found = 1'b1;
    if      (req[c0]) win = c0;
    else if (req[c1]) win = c1;
    else if (req[c2]) win = c2;
    else              win_found = 1'b0;

    // Full check uses the count before any same-cycle pop.
    issue     = win_found && (gap_cnt_q == '0) && (count_q != FULL);
    pop       = q_out_enable && (count_q != '0);
    underflow = q_out_enable && (count_q == '0);

    rr_ptr_d   = issue ? next_ch(win) : rr_ptr_q;
    gap_cnt_d  = issue ? GAP_RELOAD : ((gap_cnt_q != '0) ? gap_cnt_q - 1'b1 : gap_cnt_q);
    wr_ptr_d   = issue ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + CW'(issue) - CW'(pop);
    gnt_d      = issue ? onehot(win) : 3'b000;
    q_enable_d = issue;
    q_sel_d    = issue ? win : q_sel_q;
    done_d     = pop ? onehot(tag_mem_q[rd_ptr_q]) : 3'b000;
    busy_d     = (count_q != '0) | issue;
    err_d      = err_q | underflow;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= CH_Y;
      gap_cnt_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      gnt_q      <= '0;
      q_enable_q <= 1'b0;
      q_sel_q    <= CH_Y;
      done_q     <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      gap_cnt_q  <= gap_cnt_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      gnt_q      <= gnt_d;
      q_enable_q <= q_enable_d;
      q_sel_q    <= q_sel_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the tag storage is deliberately not reset; entries are only read
  // behind count_q, which reset clears, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (issue && !rst) tag_mem_q[wr_ptr_q] <= win;
  end

  assign gnt           = gnt_q;
  assign q_enable      = q_enable_q;
  assign q_sel         = q_sel_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_quant_scheduler.sv
// Scoreboard bench for quant_scheduler: predicted grants and completions are
// queued as stimulus is applied and matched against gnt/done as they appear.
module tb_quant_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       q_out_enable;
  logic [2:0] gnt;
  logic       q_enable;
  logic [1:0] q_sel;
  logic [2:0] done;
  logic       busy;
  logic       err_underflow;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_gnt_q  [$];
  logic [2:0] inflight_q [$];
  logic [2:0] exp_done_q [$];

  always #5 clk = ~clk;

  quant_scheduler #(
    .LATENCY   (4),
    .ISSUE_GAP (2),
    .MAX_OUT   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .gnt           (gnt),
    .q_enable      (q_enable),
    .q_sel         (q_sel),
    .q_out_enable  (q_out_enable),
    .done          (done),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] sel_of(input logic [2:0] oh);
    case (oh)
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Advance one edge, then match any grant/done pulse against the scoreboard.
  task automatic step();
    logic [2:0] e;
    @(posedge clk);
    #1;
    if (gnt !== 3'b000) begin
      if (exp_gnt_q.size() == 0) check("gnt_unexpected", gnt, 0);
      else begin
        e = exp_gnt_q.pop_front();
        check("gnt_order", gnt, e);
        check("q_sel_on_gnt", q_sel, sel_of(e));
        check("q_enable_on_gnt", q_enable, 1);
        inflight_q.push_back(e);
      end
    end
    if (done !== 3'b000) begin
      if (exp_done_q.size() == 0) check("done_unexpected", done, 0);
      else begin
        e = exp_done_q.pop_front();
        check("done_order", done, e);
      end
    end
  endtask

  task automatic complete();
    if (inflight_q.size() != 0) exp_done_q.push_back(inflight_q.pop_front());
    q_out_enable = 1'b1;
    step();
    q_out_enable = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_qen"}, q_enable, 0);
    check({tag, "_qsel"}, q_sel, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err_underflow, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 3'b000; q_out_enable = 1'b0;
    step(); step();
    rst = 1'b0;
    check_idle("reset");

    // Single Y block through a 4-cycle quantizer.
    exp_gnt_q.push_back(3'b001);
    req = 3'b001;
    step();
    check("t1_busy_c1", busy, 1);
    check("t1_qen_c1", q_enable, 1);
    req = 3'b000;
    repeat (4) begin
      step();
      check("t1_busy_mid", busy, 1);
      check("t1_qen_pulse", q_enable, 0);
    end
    complete();
    check("t1_done_c6", done, 3'b001);
    check("t1_busy_c6", busy, 1);
    step();
    check("t1_busy_c7", busy, 0);
    check("t1_done_pulse", done, 0);

    // Continuous requests from all channels, then a full-FIFO stall.
    rst = 1'b1; step(); rst = 1'b0;
    exp_gnt_q.push_back(3'b001); exp_gnt_q.push_back(3'b010);
    exp_gnt_q.push_back(3'b100); exp_gnt_q.push_back(3'b001);
    req = 3'b111;
    for (int i = 0; i < 7; i++) begin
      step();
      check("t2_qen_cycle", q_enable, (i % 2 == 0));
    end
    req = 3'b010;
    repeat (3) begin
      step();
      check("t3_stall_gnt", gnt, 0);
      check("t3_busy", busy, 1);
    end
    check("t3_qsel_held", q_sel, 0);
    exp_gnt_q.push_back(3'b010);
    complete();
    check("t3_done_first", done, 3'b001);
    check("t3_no_early_gnt", gnt, 0);
    step();
    check("t3_resume_gnt", gnt, 3'b010);
    req = 3'b000;

    // Issue and completion on the same edge.
    complete();
    check("t4_pre_done", done, 3'b010);
    req = 3'b100;
    exp_gnt_q.push_back(3'b100);
    complete();
    req = 3'b000;
    check("t4_sim_gnt", gnt, 3'b100);
    check("t4_sim_done", done, 3'b100);
    complete(); check("t4_drain0", done, 3'b001);
    complete(); check("t4_drain1", done, 3'b010);
    complete(); check("t4_drain2", done, 3'b100);
    step();
    check("t4_idle_busy", busy, 0);

    // Completion with nothing in flight.
    complete();
    check("t5_err_set", err_underflow, 1);
    check("t5_no_done", done, 0);
    step();
    check("t5_err_sticky", err_underflow, 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("t5_err_cleared", err_underflow, 0);

    // Reset with three blocks in flight.
    exp_gnt_q.push_back(3'b001); exp_gnt_q.push_back(3'b010); exp_gnt_q.push_back(3'b100);
    req = 3'b111;
    repeat (5) step();
    req = 3'b000;
    rst = 1'b1;
    inflight_q.delete();
    step();
    rst = 1'b0;
    check_idle("t6_reset");
    exp_gnt_q.push_back(3'b010);
    req = 3'b110;
    step();
    req = 3'b000;
    check("t6_gnt_cb", gnt, 3'b010);
    check("t6_qsel_cb", q_sel, 1);
    complete();
    check("t6_done_cb", done, 3'b010);
    complete();
    check("t6_stale_none", done, 0);
    check("t6_err_after", err_underflow, 1);

    check("gnt_queue_empty", exp_gnt_q.size(), 0);
    check("done_queue_empty", exp_done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
